mul_div_unit: RTL

- Iterative multiply/divide unit holding the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over 33 cycles and supports the MTHI/MTLO writes.
- Sits beside the ALU in the execute stage; its HI/LO outputs feed the execute-stage result mux for MFHI/MFLO.
- Replaces the single-cycle `a*b` product register currently inside the ALU.

---
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative 33-cycle multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixed at the end.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Magnitudes stay unsigned so that |-2^(W-1)| is representable.
    always_comb begin
        abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
        abs_b = (op[0] && b[WIDTH-1]) ? -b : b;
    end

    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // acc = {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_next  = {div_ge ? div_diff : div_shift[WIDTH-1:0],
                     acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_a  <= op[0] & a[WIDTH-1];
                        neg_b  <= op[0] & b[WIDTH-1];
                        cnt    <= '0;
                        if (op[1]) begin
                            opnd <= abs_b;
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= last_iter ? '0 : cnt + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
